// File: rtl/prbs_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs_lfsr_checker
// Description : Self-synchronising PRBS checker for a Fibonacci LFSR stream;
//               acquires lock, flywheels while locked, counts bit errors.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_lfsr_checker #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
    parameter int               LOCK_COUNT = 8,
    parameter int               LOSS_COUNT = 4,
    parameter int               ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
    output logic [ERR_W-1:0] err_count
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [FILL_W-1:0]  c_FILL_FULL = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0]  c_FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] c_LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [LOSS_W-1:0]  c_LOSS_LAST = LOSS_W'(LOSS_COUNT - 1);

    localparam logic [1:0] c_SEARCH = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [FILL_W-1:0]  r_fill;
    logic [MATCH_W-1:0] r_match;
    logic [LOSS_W-1:0]  r_loss;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_sync_loss;

    logic               w_exp;
    logic               w_mismatch;
    logic [WIDTH-1:0]   w_sr_rx;
    logic [WIDTH-1:0]   w_sr_fly;

    always_comb begin
        w_exp      = ^(r_sr & TAPS);
        w_mismatch = (in_bit != w_exp);
        w_sr_rx    = {r_sr[WIDTH-2:0], in_bit};
        w_sr_fly   = {r_sr[WIDTH-2:0], w_exp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_SEARCH;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_loss      <= '0;
            r_err_count <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_sync_loss <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            r_sync_loss <= 1'b0;
            if (clear) begin
                // sr is deliberately kept; it is refilled before it is trusted again
                r_state     <= c_SEARCH;
                r_fill      <= '0;
                r_match     <= '0;
                r_loss      <= '0;
                r_err_count <= '0;
                r_locked    <= 1'b0;
            end else if (in_valid) begin
                case (r_state)
                    c_SEARCH: begin
                        r_sr <= w_sr_rx;
                        if (r_fill != c_FILL_FULL) begin
                            r_fill <= r_fill + 1'b1;
                        end
                        // an all-zero fill is the LFSR lock-up state: keep shifting
                        if ((r_fill >= c_FILL_LAST) && (w_sr_rx != '0)) begin
                            r_state <= c_VERIFY;
                            r_match <= '0;
                        end
                    end
                    c_VERIFY: begin
                        r_sr <= w_sr_rx;
                        if (w_sr_rx == '0) begin
                            r_state <= c_SEARCH;
                            r_fill  <= '0;
                            r_match <= '0;
                        end else if (!w_mismatch) begin
                            if (r_match == c_LOCK_LAST) begin
                                r_state  <= c_LOCKED;
                                r_locked <= 1'b1;
                                r_match  <= '0;
                                r_loss   <= '0;
                            end else begin
                                r_match <= r_match + 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    c_LOCKED: begin
                        // flywheel: the local copy follows its own prediction
                        r_sr <= w_sr_fly;
                        if (w_mismatch) begin
                            r_err_pulse <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (r_loss == c_LOSS_LAST) begin
                                r_sync_loss <= 1'b1;
                                r_locked    <= 1'b0;
                                r_state     <= c_SEARCH;
                                r_fill      <= '0;
                                r_match     <= '0;
                                r_loss      <= '0;
                            end else begin
                                r_loss <= r_loss + 1'b1;
                            end
                        end else begin
                            r_loss <= '0;
                        end
                    end
                    default: begin
                        r_state  <= c_SEARCH;
                        r_fill   <= '0;
                        r_match  <= '0;
                        r_loss   <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign sync_loss = r_sync_loss;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
